vfu_cfu_req_buffer: RTL and testbench



---
 rtl/vfu_cfu_req_buffer.sv | 178 +++++++++++++++++
 tb/tb_vfu_cfu_req_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_cfu_req_buffer.sv
// Purpose: decouples the CVA5 CFU master from VFU stalls (request FIFO), caps in-flight VFU work, registers responses.
// Latency: request 1 cycle (no bypass), response 1 cycle through a 2-entry skid; m_req_en is the only combinational path.
// Backpressure: s_req_ready/m_resp_ready come from registered FIFO state, never from the opposite side's ready.

// Generic FIFO: register-array storage, count-based full/empty, head entry presented directly on o_dat.
// Latency: an entry pushed into an empty FIFO is visible at the head the following cycle.
// Backpressure: pushes while full and pops while empty are ignored; o_full/o_empty depend only on state.
module vfu_cfu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dat   = r_mem[r_rd_ptr];

    // Storage is cleared on reset so the head output reads zero while empty after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// Request buffer between the core CFU master port and the VFU CFU slave port.
// Latency: core request to VFU request 1 cycle minimum; VFU response to core response 1 cycle.
// Backpressure: requests stall at the FIFO when the VFU stalls or MAX_OUT requests are in flight.
module vfu_cfu_req_buffer #(
    parameter int DEPTH               = 4,
    parameter int MAX_OUT             = 8,
    parameter int C_M_CFU_REQ_ID_W    = 4,
    parameter int C_M_CFU_CFU_ID_W    = 2,
    parameter int C_M_CFU_STATE_ID_W  = 2,
    parameter int C_M_CFU_FUNC_ID_W   = 10,
    parameter int C_M_CFU_INSN_W      = 32,
    parameter int C_M_CFU_DATA_W      = 32,
    parameter int C_M_CFU_STATUS_W    = 3,
    parameter int REQ_PKT_W  = 1 + C_M_CFU_REQ_ID_W + C_M_CFU_CFU_ID_W + C_M_CFU_STATE_ID_W
                             + C_M_CFU_FUNC_ID_W + C_M_CFU_INSN_W + 2*C_M_CFU_DATA_W,
    parameter int RESP_PKT_W = C_M_CFU_REQ_ID_W + C_M_CFU_STATUS_W + C_M_CFU_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_req_en,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    input  logic [REQ_PKT_W-1:0]  s_req_pkt,
    output logic                  s_resp_valid,
    input  logic                  s_resp_ready,
    output logic [RESP_PKT_W-1:0] s_resp_pkt,
    output logic                  m_req_en,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [REQ_PKT_W-1:0]  m_req_pkt,
    input  logic                  m_resp_valid,
    output logic                  m_resp_ready,
    input  logic [RESP_PKT_W-1:0] m_resp_pkt,
    output logic [7:0]            outstanding,
    output logic                  resp_err
);
    logic       w_req_full;
    logic       w_req_empty;
    logic       w_req_push;
    logic       w_req_hs;
    logic       w_cap_ok;
    logic       w_resp_full;
    logic       w_resp_empty;
    logic       w_resp_hs;
    logic       w_resp_pop;
    logic [7:0] r_outstanding;
    logic       r_resp_err;

    assign m_req_en     = s_req_en;

    assign s_req_ready  = !w_req_full;
    assign w_req_push   = s_req_valid && s_req_ready;
    assign w_cap_ok     = (r_outstanding < 8'(MAX_OUT));
    assign m_req_valid  = !w_req_empty && w_cap_ok;
    assign w_req_hs     = m_req_valid && m_req_ready;

    assign m_resp_ready = !w_resp_full;
    assign w_resp_hs    = m_resp_valid && m_resp_ready;
    assign s_resp_valid = !w_resp_empty;
    assign w_resp_pop   = s_resp_valid && s_resp_ready;

    assign outstanding  = r_outstanding;
    assign resp_err     = r_resp_err;

    vfu_cfu_fifo #(
        .W     (REQ_PKT_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_req_push),
        .i_dat   (s_req_pkt),
        .i_pop   (w_req_hs),
        .o_dat   (m_req_pkt),
        .o_full  (w_req_full),
        .o_empty (w_req_empty)
    );

    // Response skid is a 2-deep FIFO so core-side ready never reaches the VFU combinationally.
    vfu_cfu_fifo #(
        .W     (RESP_PKT_W),
        .DEPTH (2)
    ) u_resp_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_resp_hs),
        .i_dat   (m_resp_pkt),
        .i_pop   (w_resp_pop),
        .o_dat   (s_resp_pkt),
        .o_full  (w_resp_full),
        .o_empty (w_resp_empty)
    );

    // Track in-flight requests; a response with nothing in flight is flagged sticky and still forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= 8'd0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_resp_hs && (r_outstanding == 8'd0)) begin
                r_resp_err <= 1'b1;
            end
            if (w_req_hs && !w_resp_hs) begin
                r_outstanding <= r_outstanding + 8'd1;
            end else if (w_resp_hs && !w_req_hs && (r_outstanding != 8'd0)) begin
                r_outstanding <= r_outstanding - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_vfu_cfu_req_buffer.sv
// Directed bench for vfu_cfu_req_buffer with DEPTH=4, MAX_OUT=2.
// Inputs change 1ns after the rising edge; outputs are sampled at that point, after state has settled.
// Expected values are hand-derived constants and packets built from the bench's own field helpers.
module tb_vfu_cfu_req_buffer;
    localparam int REQ_W  = 115;
    localparam int RESP_W = 39;

    logic              clk;
    logic              rst;
    logic              s_req_en;
    logic              s_req_valid;
    logic              s_req_ready;
    logic [REQ_W-1:0]  s_req_pkt;
    logic              s_resp_valid;
    logic              s_resp_ready;
    logic [RESP_W-1:0] s_resp_pkt;
    logic              m_req_en;
    logic              m_req_valid;
    logic              m_req_ready;
    logic [REQ_W-1:0]  m_req_pkt;
    logic              m_resp_valid;
    logic              m_resp_ready;
    logic [RESP_W-1:0] m_resp_pkt;
    logic [7:0]        outstanding;
    logic              resp_err;

    int checks = 0;
    int errors = 0;

    vfu_cfu_req_buffer #(
        .DEPTH   (4),
        .MAX_OUT (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_req_en     (s_req_en),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_pkt    (s_req_pkt),
        .s_resp_valid (s_resp_valid),
        .s_resp_ready (s_resp_ready),
        .s_resp_pkt   (s_resp_pkt),
        .m_req_en     (m_req_en),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_pkt    (m_req_pkt),
        .m_resp_valid (m_resp_valid),
        .m_resp_ready (m_resp_ready),
        .m_resp_pkt   (m_resp_pkt),
        .outstanding  (outstanding),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {cfu_csr, id, cfu, state, func, insn, data0, data1}
    function automatic logic [REQ_W-1:0] mk_req(input logic [3:0] id, input logic [31:0] d0,
                                                input logic [31:0] d1);
        return {1'b0, id, 2'b01, 2'b10, 10'h2A5, 32'hC0DE_0000, d0, d1};
    endfunction

    // {id, status, data}
    function automatic logic [RESP_W-1:0] mk_resp(input logic [3:0] id, input logic [31:0] d);
        return {id, 3'b000, d};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " s_req_ready"},  s_req_ready,  1'b1);
        check({tag, " m_req_valid"},  m_req_valid,  1'b0);
        check({tag, " s_resp_valid"}, s_resp_valid, 1'b0);
        check({tag, " m_resp_ready"}, m_resp_ready, 1'b1);
        check({tag, " outstanding"},  outstanding,  8'd0);
        check({tag, " resp_err"},     resp_err,     1'b0);
        check({tag, " m_req_pkt"},    m_req_pkt,    '0);
        check({tag, " s_resp_pkt"},   s_resp_pkt,   '0);
    endtask

    initial begin
        rst = 1'b0; s_req_en = 1'b0; s_req_valid = 1'b0; s_req_pkt = '0;
        s_resp_ready = 1'b0; m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_pkt = '0;
        #1 rst = 1'b1;
        #1;
        check_reset_vals("reset");
        s_req_en = 1'b1;
        #1 check("en_pass_1", m_req_en, 1'b1);
        s_req_en = 1'b0;
        #1 check("en_pass_0", m_req_en, 1'b0);
        cyc();
        rst = 1'b0;

        // Single request: visible one cycle after push, counted after the VFU handshake.
        m_req_ready = 1'b1; s_resp_ready = 1'b1;
        s_req_valid = 1'b1; s_req_pkt = mk_req(4'd3, 32'h11, 32'h22);
        cyc();
        s_req_valid = 1'b0;
        check("single m_req_valid", m_req_valid, 1'b1);
        check("single m_req_pkt",   m_req_pkt,   mk_req(4'd3, 32'h11, 32'h22));
        check("single out_pre",     outstanding, 8'd0);
        cyc();
        check("single out_post",    outstanding, 8'd1);
        check("single drained",     m_req_valid, 1'b0);
        m_resp_valid = 1'b1; m_resp_pkt = mk_resp(4'd3, 32'hAA);
        cyc();
        m_resp_valid = 1'b0;
        check("single resp_valid", s_resp_valid, 1'b1);
        check("single resp_pkt",   s_resp_pkt,   mk_resp(4'd3, 32'hAA));
        check("single out_zero",   outstanding,  8'd0);
        check("single no_err",     resp_err,     1'b0);
        cyc();
        check("single resp_gone",  s_resp_valid, 1'b0);

        // FIFO fill with VFU stalled: four accepted, fifth refused.
        m_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_req_valid = 1'b1;
            s_req_pkt   = mk_req(4'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
            #1 check($sformatf("fill ready[%0d]", i), s_req_ready, (i < 4));
            cyc();
        end
        s_req_valid = 1'b0;
        check("fill full",      s_req_ready, 1'b0);
        check("fill head_vld",  m_req_valid, 1'b1);
        check("fill head0",     m_req_pkt,   mk_req(4'd0, 32'h100, 32'h200));

        // Release the VFU: ids drain in order until the MAX_OUT=2 cap bites.
        m_req_ready = 1'b1;
        cyc();
        check("drain ready_back", s_req_ready, 1'b1);
        check("drain out1",       outstanding, 8'd1);
        check("drain head1",      m_req_pkt,   mk_req(4'd1, 32'h101, 32'h201));
        check("drain vld1",       m_req_valid, 1'b1);
        cyc();
        check("cap out2",   outstanding, 8'd2);
        check("cap vld0",   m_req_valid, 1'b0);
        check("cap head2",  m_req_pkt,   mk_req(4'd2, 32'h102, 32'h202));
        cyc();
        check("cap hold_vld", m_req_valid, 1'b0);
        check("cap hold_out", outstanding, 8'd2);
        m_resp_valid = 1'b1; m_resp_pkt = mk_resp(4'd0, 32'hB0);
        cyc();
        m_resp_valid = 1'b0;
        check("cap dec_out",   outstanding, 8'd1);
        check("cap issue2",    m_req_valid, 1'b1);
        check("cap issue2pkt", m_req_pkt,   mk_req(4'd2, 32'h102, 32'h202));
        check("cap resp0",     s_resp_pkt,  mk_resp(4'd0, 32'hB0));
        cyc();
        check("cap out_again", outstanding, 8'd2);
        check("cap vld_again", m_req_valid, 1'b0);
        m_resp_valid = 1'b1; m_resp_pkt = mk_resp(4'd1, 32'hB1);
        cyc();
        check("cap out3",      outstanding, 8'd1);
        check("cap issue3pkt", m_req_pkt,   mk_req(4'd3, 32'h103, 32'h203));
        check("cap issue3vld", m_req_valid, 1'b1);
        m_resp_pkt = mk_resp(4'd2, 32'hB2);
        cyc();
        check("both hs out",  outstanding, 8'd1);
        check("both hs empty", m_req_valid, 1'b0);
        m_resp_pkt = mk_resp(4'd3, 32'hB3);
        cyc();
        m_resp_valid = 1'b0;
        check("drain out0",   outstanding,  8'd0);
        check("drain resp3",  s_resp_pkt,   mk_resp(4'd3, 32'hB3));
        check("drain no_err", resp_err,     1'b0);
        cyc();
        check("drain resp_idle", s_resp_valid, 1'b0);

        // Unexpected response with nothing in flight.
        m_resp_valid = 1'b1; m_resp_pkt = mk_resp(4'd7, 32'h77);
        cyc();
        m_resp_valid = 1'b0;
        check("unexp err",      resp_err,     1'b1);
        check("unexp out",      outstanding,  8'd0);
        check("unexp fwd_vld",  s_resp_valid, 1'b1);
        check("unexp fwd_pkt",  s_resp_pkt,   mk_resp(4'd7, 32'h77));
        cyc();
        check("unexp sticky",   resp_err,     1'b1);

        // Response skid with core stalled: two accepted, third refused.
        s_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_resp_valid = 1'b1;
            m_resp_pkt   = mk_resp(4'(8 + i), 32'h800 + 32'(i));
            #1 check($sformatf("skid ready[%0d]", i), m_resp_ready, (i < 2));
            cyc();
        end
        m_resp_valid = 1'b0;
        check("skid full",   m_resp_ready, 1'b0);
        check("skid vld",    s_resp_valid, 1'b1);
        check("skid first",  s_resp_pkt,   mk_resp(4'd8, 32'h800));
        s_resp_ready = 1'b1;
        cyc();
        check("skid second", s_resp_pkt,   mk_resp(4'd9, 32'h801));
        check("skid rdy_back", m_resp_ready, 1'b1);
        cyc();
        check("skid empty",  s_resp_valid, 1'b0);
        check("skid sticky", resp_err,     1'b1);

        // Async reset with 3 queued and 2 in flight.
        m_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_req_valid = 1'b1;
            s_req_pkt   = mk_req(4'(i + 1), 32'h300 + 32'(i), 32'h400 + 32'(i));
            cyc();
        end
        s_req_valid = 1'b0;
        check("burst out2",  outstanding, 8'd2);
        check("burst capped", m_req_valid, 1'b0);
        check("burst head",  m_req_pkt,   mk_req(4'd3, 32'h302, 32'h402));
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async");
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("post_rst vld[%0d]", i), m_req_valid, 1'b0);
            check($sformatf("post_rst out[%0d]", i), outstanding, 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
